// File: rtl/x4xx_qsfp_lane_arb.sv
// Packet-level round-robin merge of four QSFP lane CHDR streams into one,
// tagging each packet with its source lane and counting packets per lane.
module x4xx_qsfp_lane_arb #(
    parameter int         CHDR_W  = 64,
    parameter logic [3:0] LANE_EN = 4'b1111,
    parameter int         CNT_W   = 16
) (
    input  logic                bus_clk,
    input  logic                bus_rst_n,
    input  logic [4*CHDR_W-1:0] s_tdata,
    input  logic [3:0]          s_tlast,
    input  logic [3:0]          s_tvalid,
    output logic [3:0]          s_tready,
    output logic [CHDR_W-1:0]   m_tdata,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [1:0]          m_lane,
    input  logic                cnt_clr,
    output logic [4*CNT_W-1:0]  pkt_cnt
);

    typedef enum logic {IDLE, PASS} state_t;

    state_t state, state_nxt;
    logic [1:0] gnt, gnt_nxt, last, last_nxt, cand;
    logic found;
    logic run;

    logic [CHDR_W-1:0] in_data;
    logic in_last, in_valid, accept, pop;

    logic [CHDR_W-1:0] head_d, spare_d;
    logic head_l, spare_l, head_v, spare_v;
    logic [1:0] head_ln, spare_ln;

    logic [3:0][CNT_W-1:0] cnt;

    always_comb begin
        in_data  = '0;
        in_last  = 1'b0;
        in_valid = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (gnt == 2'(i)) begin
                in_data  = s_tdata[i*CHDR_W +: CHDR_W];
                in_last  = s_tlast[i];
                in_valid = s_tvalid[i];
            end
        end
    end

    // A full skid buffer is exactly "spare entry occupied".
    assign accept = (state == PASS) && in_valid && !spare_v;
    assign pop    = head_v && m_tready;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (!LANE_EN[i])
                s_tready[i] = run;
            else
                s_tready[i] = (state == PASS) && (gnt == 2'(i)) && !spare_v;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        found     = 1'b0;
        cand      = '0;
        case (state)
            IDLE: begin
                // Offset 4 wraps back onto the last-served lane, so it is tried last.
                for (int unsigned k = 1; k <= 4; k++) begin
                    cand = last + 2'(k);
                    if (!found && LANE_EN[cand] && s_tvalid[cand]) begin
                        found     = 1'b1;
                        gnt_nxt   = cand;
                        last_nxt  = cand;
                        state_nxt = PASS;
                    end
                end
            end
            PASS: begin
                if (accept && in_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= 2'd3;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            head_d   <= '0;
            head_l   <= 1'b0;
            head_ln  <= '0;
            head_v   <= 1'b0;
            spare_d  <= '0;
            spare_l  <= 1'b0;
            spare_ln <= '0;
            spare_v  <= 1'b0;
        end else if (!head_v) begin
            if (accept) begin
                head_d  <= in_data;
                head_l  <= in_last;
                head_ln <= gnt;
                head_v  <= 1'b1;
            end
        end else if (!spare_v) begin
            if (pop && accept) begin
                head_d  <= in_data;
                head_l  <= in_last;
                head_ln <= gnt;
            end else if (pop) begin
                head_v <= 1'b0;
            end else if (accept) begin
                spare_d  <= in_data;
                spare_l  <= in_last;
                spare_ln <= gnt;
                spare_v  <= 1'b1;
            end
        end else if (pop) begin
            head_d  <= spare_d;
            head_l  <= spare_l;
            head_ln <= spare_ln;
            spare_v <= 1'b0;
        end
    end

    assign m_tdata  = head_d;
    assign m_tlast  = head_l;
    assign m_tvalid = head_v;
    assign m_lane   = head_ln;

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (LANE_EN[i] && s_tvalid[i] && s_tready[i] && s_tlast[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    assign pkt_cnt = cnt;

endmodule

// File: tb/tb_x4xx_qsfp_lane_arb.sv
// Directed bench for x4xx_qsfp_lane_arb: one all-lanes instance and one
// instance with lane 2 disabled and 4-bit counters.
module tb_x4xx_qsfp_lane_arb;

    localparam int W = 64;

    typedef logic [W:0]   beat_t;   // {last, data}
    typedef logic [W+2:0] obs_t;    // {lane, last, data}

    logic bus_clk = 1'b0;
    logic bus_rst_n = 1'b0;

    logic [4*W-1:0] s_tdata_a, s_tdata_b;
    logic [3:0]     s_tlast_a, s_tvalid_a, s_tready_a;
    logic [3:0]     s_tlast_b, s_tvalid_b, s_tready_b;
    logic [W-1:0]   m_tdata_a, m_tdata_b;
    logic           m_tlast_a, m_tvalid_a, m_tready_a;
    logic           m_tlast_b, m_tvalid_b, m_tready_b;
    logic [1:0]     m_lane_a, m_lane_b;
    logic           cnt_clr_a, cnt_clr_b;
    logic [63:0]    pkt_cnt_a;
    logic [15:0]    pkt_cnt_b;

    beat_t qa[4][$];
    beat_t qb[4][$];
    obs_t  oa[$];
    obs_t  ob[$];
    int    ocyc[$];
    int    cyc;
    int    nvec;
    int    nmis;

    always #5 bus_clk = ~bus_clk;

    x4xx_qsfp_lane_arb #(.CHDR_W(W), .LANE_EN(4'b1111), .CNT_W(16)) dut_a (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
        .s_tdata(s_tdata_a), .s_tlast(s_tlast_a), .s_tvalid(s_tvalid_a), .s_tready(s_tready_a),
        .m_tdata(m_tdata_a), .m_tlast(m_tlast_a), .m_tvalid(m_tvalid_a), .m_tready(m_tready_a),
        .m_lane(m_lane_a), .cnt_clr(cnt_clr_a), .pkt_cnt(pkt_cnt_a)
    );

    x4xx_qsfp_lane_arb #(.CHDR_W(W), .LANE_EN(4'b1011), .CNT_W(4)) dut_b (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
        .s_tdata(s_tdata_b), .s_tlast(s_tlast_b), .s_tvalid(s_tvalid_b), .s_tready(s_tready_b),
        .m_tdata(m_tdata_b), .m_tlast(m_tlast_b), .m_tvalid(m_tvalid_b), .m_tready(m_tready_b),
        .m_lane(m_lane_b), .cnt_clr(cnt_clr_b), .pkt_cnt(pkt_cnt_b)
    );

    task automatic chk(input string tag, input logic [W+2:0] got, input logic [W+2:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pay(input int lane, input int seq);
        logic [W-1:0] d;
        d = '0;
        d[9:8] = lane[1:0];
        d[7:0] = seq[7:0];
        return d;
    endfunction

    function automatic obs_t exp_beat(input int lane, input bit lst, input int seq);
        return {lane[1:0], lst, pay(lane, seq)};
    endfunction

    task automatic add_pkt(input bit to_b, input int lane, input int nb, input int seq0);
        for (int b = 0; b < nb; b++) begin
            beat_t x;
            x = {(b == nb - 1), pay(lane, seq0 + b)};
            if (to_b) qb[lane].push_back(x);
            else      qa[lane].push_back(x);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid_a[i] = (qa[i].size() > 0);
            s_tdata_a[i*W +: W] = (qa[i].size() > 0) ? qa[i][0][W-1:0] : '0;
            s_tlast_a[i] = (qa[i].size() > 0) ? qa[i][0][W] : 1'b0;
            s_tvalid_b[i] = (qb[i].size() > 0);
            s_tdata_b[i*W +: W] = (qb[i].size() > 0) ? qb[i][0][W-1:0] : '0;
            s_tlast_b[i] = (qb[i].size() > 0) ? qb[i][0][W] : 1'b0;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            qa[i].delete();
            qb[i].delete();
        end
    endtask

    // Handshakes are resolved from values held just before the edge; outputs
    // are re-sampled 1 time unit after it.
    task automatic tick();
        logic [3:0] fa, fb;
        logic ofa, ofb, stall;
        obs_t held;
        fa    = s_tvalid_a & s_tready_a;
        fb    = s_tvalid_b & s_tready_b;
        ofa   = m_tvalid_a & m_tready_a;
        ofb   = m_tvalid_b & m_tready_b;
        stall = m_tvalid_a & ~m_tready_a;
        held  = {m_lane_a, m_tlast_a, m_tdata_a};
        if (ofa) oa.push_back({m_lane_a, m_tlast_a, m_tdata_a});
        if (ofb) ob.push_back({m_lane_b, m_tlast_b, m_tdata_b});
        @(posedge bus_clk);
        #1;
        cyc++;
        if (ofa) ocyc.push_back(cyc);
        if (stall && bus_rst_n) begin
            chk("stall_valid", m_tvalid_a, 1);
            chk("stall_hold", {m_lane_a, m_tlast_a, m_tdata_a}, held);
        end
        for (int i = 0; i < 4; i++) begin
            if (fa[i]) void'(qa[i].pop_front());
            if (fb[i]) void'(qb[i].pop_front());
        end
        drive();
    endtask

    initial begin
        bit done;
        nvec = 0;
        nmis = 0;
        cyc  = 0;
        m_tready_a = 1'b0;
        m_tready_b = 1'b1;
        cnt_clr_a  = 1'b0;
        cnt_clr_b  = 1'b0;
        drive();
        repeat (3) tick();
        bus_rst_n = 1'b1;

        // Lane 0 single beat, then lane 1 stuck mid-packet behind a full buffer.
        add_pkt(0, 0, 1, 0);
        add_pkt(0, 1, 4, 0);
        drive();
        repeat (12) tick();
        chk("pre_rst_mvalid", m_tvalid_a, 1);
        chk("pre_rst_mlane", m_lane_a, 0);
        chk("pre_rst_mlast", m_tlast_a, 1);
        chk("pre_rst_mdata", m_tdata_a, pay(0, 0));
        chk("pre_rst_cnt", pkt_cnt_a, 64'h1);
        chk("pre_rst_sready", s_tready_a, 0);
        chk("pre_rst_l1_left", qa[1].size(), 3);
        #2 bus_rst_n = 1'b0;
        #1;
        chk("rst_mvalid", m_tvalid_a, 0);
        chk("rst_mlast", m_tlast_a, 0);
        chk("rst_mdata", m_tdata_a, 0);
        chk("rst_mlane", m_lane_a, 0);
        chk("rst_sready_a", s_tready_a, 0);
        chk("rst_sready_b", s_tready_b, 0);
        chk("rst_cnt", pkt_cnt_a, 0);
        flush();
        drive();
        repeat (3) tick();
        bus_rst_n  = 1'b1;
        m_tready_a = 1'b1;

        // All lanes send three 3-beat packets; grant order must start at lane 0.
        oa.delete();
        ocyc.delete();
        for (int p = 0; p < 3; p++)
            for (int l = 0; l < 4; l++)
                add_pkt(0, l, 3, p * 3);
        drive();
        for (int n = 0; n < 300 && oa.size() < 36; n++) tick();
        chk("rr_count", oa.size(), 36);
        for (int k = 0; k < 12; k++)
            for (int b = 0; b < 3; b++)
                if (k * 3 + b < oa.size())
                    chk("rr_beat", oa[k*3+b], exp_beat(k % 4, (b == 2), (k / 4) * 3 + b));
        if (ocyc.size() > 0) chk("rr_span", ocyc[$] - ocyc[0], 46);

        // Lane 2, 8 beats, random downstream stalls.
        oa.delete();
        add_pkt(0, 2, 8, 0);
        drive();
        for (int n = 0; n < 300 && oa.size() < 8; n++) begin
            m_tready_a = 1'($urandom_range(0, 1));
            tick();
        end
        m_tready_a = 1'b1;
        repeat (5) tick();
        chk("bp_count", oa.size(), 8);
        for (int b = 0; b < 8; b++)
            if (b < oa.size()) chk("bp_beat", oa[b], exp_beat(2, (b == 7), b));

        // Reset while the 2nd beat of a lane-0 packet is offered.
        oa.delete();
        m_tready_a = 1'b0;
        add_pkt(0, 0, 4, 0);
        drive();
        for (int n = 0; n < 20 && qa[0].size() > 3; n++) tick();
        chk("rp_first_acc", qa[0].size(), 3);
        bus_rst_n = 1'b0;
        #1;
        flush();
        drive();
        repeat (3) tick();
        bus_rst_n  = 1'b1;
        m_tready_a = 1'b1;
        add_pkt(0, 1, 2, 0);
        drive();
        repeat (20) tick();
        chk("rp_count", oa.size(), 2);
        if (oa.size() > 0) chk("rp_beat0", oa[0], exp_beat(1, 0, 0));
        if (oa.size() > 1) chk("rp_beat1", oa[1], exp_beat(1, 1, 1));
        chk("rp_cnt", pkt_cnt_a, 64'h1_0000);

        // Disabled lane 2 streams; lanes 0 and 1 each send one packet.
        ob.delete();
        for (int k = 0; k < 10; k++) add_pkt(1, 2, 3, k * 3);
        add_pkt(1, 0, 2, 0);
        add_pkt(1, 1, 3, 0);
        drive();
        for (int n = 0; n < 40; n++) begin
            chk("dis_ready2", s_tready_b[2], 1);
            tick();
        end
        chk("dis_drained2", qb[2].size(), 0);
        chk("dis_count", ob.size(), 5);
        if (ob.size() > 0) chk("dis_b0", ob[0], exp_beat(0, 0, 0));
        if (ob.size() > 1) chk("dis_b1", ob[1], exp_beat(0, 1, 1));
        for (int b = 0; b < 3; b++)
            if (b + 2 < ob.size()) chk("dis_l1", ob[b+2], exp_beat(1, (b == 2), b));
        chk("dis_cnt", pkt_cnt_b, 16'h0011);

        // 4-bit counter saturation, then clear colliding with an increment.
        for (int k = 0; k < 20; k++) add_pkt(1, 3, 1, k);
        drive();
        for (int n = 0; n < 100 && qb[3].size() > 0; n++) tick();
        repeat (3) tick();
        chk("cnt_sat", pkt_cnt_b, 16'hF011);
        add_pkt(1, 3, 1, 20);
        drive();
        done = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            if (s_tvalid_b[3] && s_tready_b[3]) begin
                cnt_clr_b = 1'b1;
                tick();
                cnt_clr_b = 1'b0;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        chk("clr_hit", done, 1);
        chk("clr_accepted", qb[3].size(), 0);
        chk("clr_wins", pkt_cnt_b, 0);
        add_pkt(1, 3, 1, 21);
        drive();
        repeat (5) tick();
        chk("post_clr_cnt", pkt_cnt_b, 16'h1000);
        chk("b_total", ob.size(), 27);
        if (ob.size() > 0) chk("b_last", ob[$], exp_beat(3, 1, 21));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
